// File: rtl/risc_mini_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: opcodes, datapath
// select codes, ALU operations and the controller state enum.
package risc_mini_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] EXT_I = 3'd0;
  localparam logic [2:0] EXT_U = 3'd1;
  localparam logic [2:0] EXT_S = 3'd2;
  localparam logic [2:0] EXT_B = 3'd3;
  localparam logic [2:0] EXT_J = 3'd4;

  localparam logic [1:0] BSRC_BUSB = 2'd0;
  localparam logic [1:0] BSRC_FOUR = 2'd1;
  localparam logic [1:0] BSRC_IMM  = 2'd2;

  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_JAL  = 3'd1;
  localparam logic [2:0] BR_JALR = 3'd2;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_COPYB = 4'd10;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  // Register/immediate arithmetic op from funct3; alt selects SUB/SRA.
  function automatic logic [3:0] alu_of_f3(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'd0:    op = alt ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = alt ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Conditional branch code: BEQ 4, BNE 5, BLT/BLTU 6, BGE/BGEU 7.
  function automatic logic [2:0] br_code(input logic [2:0] f3);
    return {1'b1, f3[2], f3[0]};
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational instruction-field decode: ALU operation and legality of the
// opcode/funct3/funct7 combination.
module alu_decode
  import risc_mini_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  output logic [3:0] o_aluctr_c,
  output logic       o_legal_c
);

  logic w_f7_base;
  logic w_f7_alt;

  assign w_f7_base = (i_funct7 == 7'b000_0000);
  assign w_f7_alt  = (i_funct7 == 7'b010_0000);

  always_comb begin
    o_aluctr_c = ALU_ADD;
    o_legal_c  = 1'b0;
    case (i_opcode)
      OPC_OP: begin
        o_aluctr_c = alu_of_f3(i_funct3, w_f7_alt);
        o_legal_c  = w_f7_base | (w_f7_alt & ((i_funct3 == 3'd0) | (i_funct3 == 3'd5)));
      end
      OPC_OPIMM: begin
        // Only the shift-immediates constrain funct7; SRAI is picked by bit 5.
        o_aluctr_c = alu_of_f3(i_funct3, (i_funct3 == 3'd5) & i_funct7[5]);
        if (i_funct3 == 3'd1)      o_legal_c = w_f7_base;
        else if (i_funct3 == 3'd5) o_legal_c = w_f7_base | w_f7_alt;
        else                       o_legal_c = 1'b1;
      end
      OPC_LOAD:  o_legal_c = (i_funct3 != 3'd3) & (i_funct3 < 3'd6);
      OPC_STORE: o_legal_c = (i_funct3 < 3'd3);
      OPC_LUI: begin
        o_aluctr_c = ALU_COPYB;
        o_legal_c  = 1'b1;
      end
      OPC_AUIPC, OPC_JAL: o_legal_c = 1'b1;
      OPC_JALR:  o_legal_c = (i_funct3 == 3'd0);
      OPC_BRANCH: begin
        o_aluctr_c = !i_funct3[2] ? ALU_SUB : (i_funct3[1] ? ALU_SLTU : ALU_SLT);
        o_legal_c  = (i_funct3[2:1] != 2'b01);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle RV32I controller: owns the IR and the shared memory handshake,
// sequences FETCH/DECODE/EXEC/MEM/WB and counts retired instructions.
module mc_ctrl
  import risc_mini_pkg::*;
#(
  parameter logic [31:0] RESET_IR = 32'h0000_0013,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [31:0]      Instr_in,
  input  logic             mem_ready,
  output logic [31:0]      Instr,
  output logic             IFetch,
  output logic             MemRd,
  output logic             MemWr,
  output logic [2:0]       MemOp,
  output logic [2:0]       ExtOp,
  output logic             ALUASrc,
  output logic [1:0]       ALUBSrc,
  output logic [3:0]       ALUctr,
  output logic             RegWr,
  output logic             MemtoReg,
  output logic             PCWr,
  output logic [2:0]       Branch,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [31:0]      r_ir;
  logic             r_illegal;
  logic [CNT_W-1:0] r_instret;

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic       w_is_load, w_is_store, w_is_branch, w_is_jal, w_is_jalr;
  logic [3:0] w_aluctr;
  logic       w_legal;
  logic [2:0] w_extop;
  logic       w_asrc;
  logic [1:0] w_bsrc;

  assign w_opcode    = r_ir[6:0];
  assign w_funct3    = r_ir[14:12];
  assign w_funct7    = r_ir[31:25];
  assign w_is_load   = (w_opcode == OPC_LOAD);
  assign w_is_store  = (w_opcode == OPC_STORE);
  assign w_is_branch = (w_opcode == OPC_BRANCH);
  assign w_is_jal    = (w_opcode == OPC_JAL);
  assign w_is_jalr   = (w_opcode == OPC_JALR);

  alu_decode u_alu_decode (
    .i_opcode   (w_opcode),
    .i_funct3   (w_funct3),
    .i_funct7   (w_funct7),
    .o_aluctr_c (w_aluctr),
    .o_legal_c  (w_legal)
  );

  // Per-class operand and immediate selects, held through EXEC/MEM/WB.
  always_comb begin
    w_extop = EXT_I;
    w_asrc  = 1'b0;
    w_bsrc  = BSRC_BUSB;
    case (w_opcode)
      OPC_OPIMM, OPC_LOAD: w_bsrc = BSRC_IMM;
      OPC_STORE: begin
        w_extop = EXT_S;
        w_bsrc  = BSRC_IMM;
      end
      OPC_LUI: begin
        w_extop = EXT_U;
        w_bsrc  = BSRC_IMM;
      end
      OPC_AUIPC: begin
        w_extop = EXT_U;
        w_asrc  = 1'b1;
        w_bsrc  = BSRC_IMM;
      end
      OPC_JAL: begin
        w_extop = EXT_J;
        w_asrc  = 1'b1;
        w_bsrc  = BSRC_FOUR;
      end
      OPC_JALR: begin
        w_asrc = 1'b1;
        w_bsrc = BSRC_FOUR;
      end
      OPC_BRANCH: w_extop = EXT_B;
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) r_state <= ST_FETCH;
    else        r_state <= w_state_nxt;
  end

  // Next state and control outputs; the reset state is FETCH, so only IFetch
  // needs qualifying to keep every enable low while Rst_n is held.
  always_comb begin
    w_state_nxt = r_state;
    IFetch      = 1'b0;
    MemRd       = 1'b0;
    MemWr       = 1'b0;
    MemOp       = 3'd0;
    ExtOp       = EXT_I;
    ALUASrc     = 1'b0;
    ALUBSrc     = BSRC_BUSB;
    ALUctr      = ALU_ADD;
    RegWr       = 1'b0;
    MemtoReg    = 1'b0;
    PCWr        = 1'b0;
    Branch      = BR_NONE;
    case (r_state)
      ST_FETCH: begin
        IFetch = Rst_n;
        if (mem_ready) w_state_nxt = ST_DECODE;
      end
      ST_DECODE: w_state_nxt = w_legal ? ST_EXEC : ST_TRAP;
      ST_EXEC: begin
        ExtOp   = w_extop;
        ALUASrc = w_asrc;
        ALUBSrc = w_bsrc;
        ALUctr  = w_aluctr;
        if (w_is_branch) begin
          PCWr        = 1'b1;
          Branch      = br_code(w_funct3);
          w_state_nxt = ST_FETCH;
        end else if (w_is_load || w_is_store) begin
          w_state_nxt = ST_MEM;
        end else begin
          w_state_nxt = ST_WB;
        end
      end
      ST_MEM: begin
        ExtOp   = w_extop;
        ALUASrc = w_asrc;
        ALUBSrc = w_bsrc;
        ALUctr  = w_aluctr;
        MemOp   = w_funct3;
        MemRd   = w_is_load;
        MemWr   = w_is_store;
        // A store retires on the cycle its write completes.
        if (mem_ready) begin
          if (w_is_load) begin
            w_state_nxt = ST_WB;
          end else begin
            PCWr        = 1'b1;
            w_state_nxt = ST_FETCH;
          end
        end
      end
      ST_WB: begin
        ExtOp       = w_extop;
        ALUASrc     = w_asrc;
        ALUBSrc     = w_bsrc;
        ALUctr      = w_aluctr;
        RegWr       = 1'b1;
        PCWr        = 1'b1;
        MemtoReg    = w_is_load;
        Branch      = w_is_jal ? BR_JAL : (w_is_jalr ? BR_JALR : BR_NONE);
        w_state_nxt = ST_FETCH;
      end
      ST_TRAP: w_state_nxt = ST_TRAP;
      default: w_state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_ir      <= RESET_IR;
      r_illegal <= 1'b0;
      r_instret <= '0;
    end else begin
      if (r_state == ST_FETCH && mem_ready) r_ir <= Instr_in;
      if (r_state == ST_DECODE && !w_legal) r_illegal <= 1'b1;
      if (PCWr) r_instret <= r_instret + CNT_W'(1);
    end
  end

  assign Instr   = r_ir;
  assign illegal = r_illegal;
  assign instret = r_instret;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed and randomized bench for mc_ctrl: each instruction is expanded into
// an expected per-cycle trace from the ISA class rules and compared cycle by cycle.
module tb_mc_ctrl;

  localparam int unsigned CW  = 5;
  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [6:0] O_LUI = 7'h37, O_AUIPC = 7'h17, O_JAL = 7'h6F, O_JALR = 7'h67;
  localparam logic [6:0] O_BR = 7'h63, O_LD = 7'h03, O_ST = 7'h23, O_OPI = 7'h13, O_OP = 7'h33;

  typedef struct packed {
    logic       ifetch, memrd, memwr;
    logic [2:0] memop, extop;
    logic       asrc;
    logic [1:0] bsrc;
    logic [3:0] alu;
    logic       regwr, memtoreg, pcwr;
    logic [2:0] branch;
    logic       illegal;
  } ctl_t;

  typedef struct {
    ctl_t          ctl;
    logic          rdy;
    logic [31:0]   din;
    logic [31:0]   ir;
    logic [CW-1:0] cnt;
  } ent_t;

  logic          Clk, Rst_n, mem_ready;
  logic [31:0]   Instr_in, Instr;
  logic          IFetch, MemRd, MemWr, ALUASrc, RegWr, MemtoReg, PCWr, illegal;
  logic [2:0]    MemOp, ExtOp, Branch;
  logic [1:0]    ALUBSrc;
  logic [3:0]    ALUctr;
  logic [CW-1:0] instret;

  int            checks, failures;
  string         step;
  ent_t          tr[$];
  logic [31:0]   m_ir;
  logic [CW-1:0] m_cnt;

  mc_ctrl #(.RESET_IR(NOP), .CNT_W(CW)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Instr_in(Instr_in), .mem_ready(mem_ready),
    .Instr(Instr), .IFetch(IFetch), .MemRd(MemRd), .MemWr(MemWr), .MemOp(MemOp),
    .ExtOp(ExtOp), .ALUASrc(ALUASrc), .ALUBSrc(ALUBSrc), .ALUctr(ALUctr),
    .RegWr(RegWr), .MemtoReg(MemtoReg), .PCWr(PCWr), .Branch(Branch),
    .illegal(illegal), .instret(instret)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s/%s observed=%0h expected=%0h", step, tag, obs, exp);
    end
  endtask

  function automatic ctl_t obs_ctl();
    return {IFetch, MemRd, MemWr, MemOp, ExtOp, ALUASrc, ALUBSrc, ALUctr,
            RegWr, MemtoReg, PCWr, Branch, illegal};
  endfunction

  function automatic bit ref_legal(input logic [31:0] ins);
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = ins[14:12];
    f7 = ins[31:25];
    case (ins[6:0])
      O_LUI, O_AUIPC, O_JAL: return 1'b1;
      O_JALR: return f3 == 3'd0;
      O_BR:   return !(f3 == 3'd2 || f3 == 3'd3);
      O_LD:   return f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5;
      O_ST:   return f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2;
      O_OPI:  return (f3 == 3'd1) ? (f7 == 7'h00)
                   : (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
      O_OP:   return f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      default: return 1'b0;
    endcase
  endfunction

  // Arithmetic op by mnemonic: add/sub sll slt sltu xor srl/sra or and.
  function automatic logic [3:0] arith_op(input logic [2:0] f3, input bit alt);
    case (f3)
      3'd0: return alt ? 4'd1 : 4'd0;
      3'd1: return 4'd2;
      3'd2: return 4'd3;
      3'd3: return 4'd4;
      3'd4: return 4'd5;
      3'd5: return alt ? 4'd7 : 4'd6;
      3'd6: return 4'd8;
      default: return 4'd9;
    endcase
  endfunction

  // Operand/immediate/ALU setting each instruction class needs.
  function automatic ctl_t cls_ctl(input logic [31:0] ins);
    ctl_t c;
    logic [2:0] f3;
    c  = '0;
    f3 = ins[14:12];
    case (ins[6:0])
      O_OP:    c.alu = arith_op(f3, ins[30]);
      O_OPI:   begin c.bsrc = 2'd2; c.alu = arith_op(f3, f3 == 3'd5 && ins[30]); end
      O_LD:    c.bsrc = 2'd2;
      O_ST:    begin c.bsrc = 2'd2; c.extop = 3'd2; end
      O_LUI:   begin c.bsrc = 2'd2; c.extop = 3'd1; c.alu = 4'd10; end
      O_AUIPC: begin c.asrc = 1'b1; c.bsrc = 2'd2; c.extop = 3'd1; end
      O_JAL:   begin c.asrc = 1'b1; c.bsrc = 2'd1; c.extop = 3'd4; end
      O_JALR:  begin c.asrc = 1'b1; c.bsrc = 2'd1; end
      O_BR:    begin
        c.extop = 3'd3;
        c.alu   = (f3 < 3'd2) ? 4'd1 : ((f3 < 3'd6) ? 4'd3 : 4'd4);
      end
      default: ;
    endcase
    return c;
  endfunction

  task automatic push(input ctl_t c, input logic rdy, input logic [31:0] din);
    ent_t e;
    e.ctl = c; e.rdy = rdy; e.din = din; e.ir = m_ir; e.cnt = m_cnt;
    tr.push_back(e);
    if (c.pcwr) m_cnt = m_cnt + 1'b1;
  endtask

  // Expected cycle-by-cycle behaviour of one instruction with given wait counts.
  task automatic build(input logic [31:0] ins, input int wf, input int wm);
    ctl_t c, e;
    logic [2:0] f3;
    bit ld, st, br;
    logic [2:0] brtab [8];
    brtab = '{3'd4, 3'd5, 3'd0, 3'd0, 3'd6, 3'd7, 3'd6, 3'd7};
    f3 = ins[14:12];
    ld = (ins[6:0] == O_LD);
    st = (ins[6:0] == O_ST);
    br = (ins[6:0] == O_BR);
    tr.delete();
    for (int i = 0; i <= wf; i++) begin
      e = '0; e.ifetch = 1'b1;
      push(e, i == wf, (i == wf) ? ins : $urandom);
    end
    m_ir = ins;
    push('0, 1'($urandom), $urandom);
    if (!ref_legal(ins)) return;
    c = cls_ctl(ins);
    e = c;
    if (br) begin e.pcwr = 1'b1; e.branch = brtab[f3]; end
    push(e, 1'($urandom), $urandom);
    if (ld || st) begin
      for (int i = 0; i <= wm; i++) begin
        e = c; e.memop = f3; e.memrd = ld; e.memwr = st;
        e.pcwr = st && (i == wm);
        push(e, i == wm, $urandom);
      end
    end
    if (!br && !st) begin
      e = c; e.regwr = 1'b1; e.pcwr = 1'b1; e.memtoreg = ld;
      e.branch = (ins[6:0] == O_JAL) ? 3'd1 : ((ins[6:0] == O_JALR) ? 3'd2 : 3'd0);
      push(e, 1'($urandom), $urandom);
    end
  endtask

  task automatic run(input int lim);
    int n;
    n = (lim < tr.size()) ? lim : tr.size();
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      mem_ready = tr[i].rdy;
      Instr_in  = tr[i].din;
      #1;
      chk($sformatf("ctl@%0d", i), 32'(obs_ctl()), 32'(tr[i].ctl));
      chk($sformatf("instret@%0d", i), 32'(instret), 32'(tr[i].cnt));
      chk($sformatf("Instr@%0d", i), Instr, tr[i].ir);
    end
  endtask

  task automatic do_instr(input string name, input logic [31:0] ins, input int wf, input int wm);
    step = name;
    build(ins, wf, wm);
    run(tr.size());
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0] opc [9];
    opc = '{O_LUI, O_AUIPC, O_JAL, O_JALR, O_BR, O_LD, O_ST, O_OPI, O_OP};
    do begin
      r = $urandom;
      r[6:0] = opc[$urandom_range(0, 8)];
      if ($urandom_range(0, 1) == 0) r[31:25] = r[30] ? 7'h20 : 7'h00;
    end while (!ref_legal(r));
    return r;
  endfunction

  task automatic check_reset_state(input string name);
    step = name;
    chk("IFetch", 32'(IFetch), 32'd0);
    chk("MemWr", 32'(MemWr), 32'd0);
    chk("MemRd", 32'(MemRd), 32'd0);
    chk("PCWr", 32'(PCWr), 32'd0);
    chk("RegWr", 32'(RegWr), 32'd0);
    chk("Instr", Instr, NOP);
    chk("instret", 32'(instret), 32'd0);
    chk("illegal", 32'(illegal), 32'd0);
  endtask

  task automatic release_reset();
    @(negedge Clk);
    Rst_n     = 1'b1;
    mem_ready = 1'b0;
    m_ir      = NOP;
    m_cnt     = '0;
    #1;
    chk("IFetch_after_release", 32'(IFetch), 32'd1);
  endtask

  initial begin
    checks = 0; failures = 0;
    Rst_n = 1'b1; mem_ready = 1'b0; Instr_in = '0;
    #1 Rst_n = 1'b0;
    @(posedge Clk); #1;
    check_reset_state("reset");
    release_reset();

    do_instr("addi", 32'h0050_0093, 0, 0);
    do_instr("lw_waits", 32'h0080_A103, 2, 2);
    do_instr("sw", 32'h0020_A223, 0, 3);
    do_instr("beq", 32'h0000_0463, 0, 0);
    do_instr("jal", 32'h0100_00EF, 1, 0);
    do_instr("jalr", 32'h0000_8067, 0, 0);
    do_instr("lui", 32'h1234_50B7, 0, 0);

    for (int k = 0; k < 45; k++)
      do_instr($sformatf("rand%0d", k), rand_instr(), $urandom_range(0, 3), $urandom_range(0, 3));

    // Abort a store part-way through its MEM wait.
    step = "store_abort";
    build(32'h0020_A223, 0, 3);
    run(5);
    chk("MemWr_before", 32'(MemWr), 32'd1);
    #2 Rst_n = 1'b0;
    #1;
    check_reset_state("store_abort_reset");
    release_reset();

    for (int k = 0; k < 4; k++)
      do_instr($sformatf("post_abort%0d", k), rand_instr(), $urandom_range(0, 2), $urandom_range(0, 2));

    // Illegal instruction: trap is sticky regardless of mem_ready.
    step = "trap";
    build(32'hFFFF_FFFF, 1, 0);
    for (int i = 0; i < 10; i++) begin
      ctl_t t;
      t = '0; t.illegal = 1'b1;
      push(t, 1'(i % 2), $urandom);
    end
    run(tr.size());
    #2 Rst_n = 1'b0;
    #1;
    check_reset_state("trap_reset");
    release_reset();

    do_instr("addi_final", 32'h0050_0093, 0, 0);
    @(negedge Clk); #1;
    step = "final";
    chk("instret", 32'(instret), 32'(m_cnt));
    chk("IFetch", 32'(IFetch), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
